string_dispatch: RTL and testbench



---
 rtl/string_dispatch.sv | 169 ++++++++++++++++
 tb/tb_string_dispatch.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/string_dispatch.sv
// rtl/string_dispatch.sv - FIFO-to-LED-string pixel dispatcher with one read in flight
module string_dispatch #(
  parameter int NUM_STRINGS       = 2,
  parameter int PIXELS_PER_STRING = 300,
  parameter int FIFO_COUNT_WIDTH  = 13,
  parameter int READ_TIMEOUT      = 8,
  localparam int SW = (NUM_STRINGS > 1) ? $clog2(NUM_STRINGS) : 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic                        pack_mode,
  input  logic                        resync,
  input  logic [FIFO_COUNT_WIDTH-1:0] fifo_count,
  output logic                        fifo_rd,
  input  logic [15:0]                 fifo_data,
  input  logic                        fifo_data_valid,
  input  logic [NUM_STRINGS-1:0]      string_ready,
  output logic [23:0]                 pixel_data,
  output logic [NUM_STRINGS-1:0]      pixel_valid,
  output logic [SW-1:0]               active_string,
  output logic                        frame_done,
  output logic                        read_error
);

  localparam int CW = (PIXELS_PER_STRING > 1) ? $clog2(PIXELS_PER_STRING + 1) : 1;
  localparam int TW = $clog2(READ_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, READ, WAIT, EMIT} state_t;

  state_t                 state;
  state_t                 state_next;
  logic [CW-1:0]          pix_cnt;
  logic [1:0]             phase;
  logic [15:0]            hold;
  logic [23:0]            pend;
  logic                   mode;
  logic                   resync_pend;
  logic [TW-1:0]          wait_cnt;
  logic [NUM_STRINGS-1:0] onehot;

  logic ready_cur;
  logic at_start;
  logic start_read;
  logic timeout;
  logic word_yields;
  logic last_pix;
  logic last_str;

  assign ready_cur   = string_ready[active_string];
  assign at_start    = (pix_cnt == '0) && (active_string == '0) && (phase == 2'd0);
  assign start_read  = enable && (fifo_count != '0) && ready_cur && !resync_pend && !resync;
  assign timeout     = (wait_cnt == TW'(READ_TIMEOUT));
  assign word_yields = !mode || (phase != 2'd0);
  assign last_pix    = (pix_cnt == CW'(PIXELS_PER_STRING - 1));
  assign last_str    = (active_string == SW'(NUM_STRINGS - 1));

  // One-hot strobe pattern for the string currently being fed
  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_STRINGS; i++) begin
      onehot[i] = (active_string == SW'(i));
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic: one pop, wait for its word, optionally emit, back to idle
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start_read) state_next = READ;
      READ: state_next = WAIT;
      WAIT: begin
        if (fifo_data_valid)  state_next = word_yields ? EMIT : IDLE;
        else if (timeout)     state_next = IDLE;
      end
      EMIT: if (ready_cur) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Moore pop strobe; timeout flag raised on the last allowed wait cycle without data
  always_comb begin
    fifo_rd    = (state == READ);
    read_error = (state == WAIT) && !fifo_data_valid && timeout;
  end

  // Datapath: wait counter, unpacking, position counters and pixel outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_cnt       <= '0;
      active_string <= '0;
      phase         <= 2'd0;
      hold          <= 16'h0;
      pend          <= 24'h0;
      mode          <= 1'b0;
      resync_pend   <= 1'b0;
      wait_cnt      <= '0;
      pixel_data    <= 24'h0;
      pixel_valid   <= '0;
      frame_done    <= 1'b0;
    end else begin
      pixel_valid <= '0;
      frame_done  <= 1'b0;

      if (resync)              resync_pend <= 1'b1;
      else if (state == IDLE)  resync_pend <= 1'b0;

      if (state == IDLE && resync_pend) begin
        pix_cnt       <= '0;
        active_string <= '0;
        phase         <= 2'd0;
        hold          <= 16'h0;
      end

      // Packing mode can only change on a frame boundary
      if (state == IDLE && at_start) mode <= pack_mode;

      if (state == READ)      wait_cnt <= TW'(1);
      else if (state == WAIT) wait_cnt <= wait_cnt + TW'(1);

      if (state == WAIT && fifo_data_valid) begin
        if (!mode) begin
          pend <= {fifo_data[15:11], fifo_data[15:13],
                   fifo_data[10:5],  fifo_data[10:9],
                   fifo_data[4:0],   fifo_data[4:2]};
        end else begin
          case (phase)
            2'd0: begin
              hold  <= fifo_data;
              phase <= 2'd1;
            end
            2'd1: begin
              pend      <= {hold, fifo_data[15:8]};
              hold[7:0] <= fifo_data[7:0];
              phase     <= 2'd2;
            end
            default: begin
              pend  <= {hold[7:0], fifo_data};
              phase <= 2'd0;
            end
          endcase
        end
      end

      if (state == EMIT && ready_cur) begin
        pixel_valid <= onehot;
        pixel_data  <= pend;
        if (last_pix) begin
          pix_cnt <= '0;
          if (last_str) begin
            active_string <= '0;
            frame_done    <= 1'b1;
          end else begin
            active_string <= active_string + SW'(1);
          end
        end else begin
          pix_cnt <= pix_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_string_dispatch.sv
// tb/tb_string_dispatch.sv - self-checking bench for string_dispatch
module tb_string_dispatch;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic        pack_mode;
  logic        resync;
  logic [12:0] fifo_count;
  logic        fifo_rd;
  logic [15:0] fifo_data;
  logic        fifo_data_valid;
  logic [1:0]  string_ready;
  logic [23:0] pixel_data;
  logic [1:0]  pixel_valid;
  logic [0:0]  active_string;
  logic        frame_done;
  logic        read_error;

  string_dispatch #(
    .NUM_STRINGS(2),
    .PIXELS_PER_STRING(3),
    .FIFO_COUNT_WIDTH(13),
    .READ_TIMEOUT(8)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .pack_mode(pack_mode),
    .resync(resync),
    .fifo_count(fifo_count),
    .fifo_rd(fifo_rd),
    .fifo_data(fifo_data),
    .fifo_data_valid(fifo_data_valid),
    .string_ready(string_ready),
    .pixel_data(pixel_data),
    .pixel_valid(pixel_valid),
    .active_string(active_string),
    .frame_done(frame_done),
    .read_error(read_error)
  );

  typedef struct packed {
    logic [23:0] pix;
    logic [1:0]  pv;
    logic        fd;
  } exp_t;

  typedef struct {
    bit          mode;
    int          nw;
    logic [15:0] w0, w1, w2;
    int          np;
    logic [23:0] p0, p1;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          rd_count = 0;
  int          pv_count = 0;
  int          err_count = 0;
  int          t_err    = 0;
  int          m_cnt    = 0;
  int          m_str    = 0;
  int          fixed_lat = 0;
  bit          drop     = 0;
  bit          stray_req = 0;
  bit          expect_err = 0;
  bit          prev_rd  = 0;
  logic [15:0] wq[$];
  exp_t        exp_q[$];
  int          rd_times[$];
  int          pv_times[$];
  vec_t        tbl[9];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model of string position: stamps each expected pixel with its strobe
  task automatic push_pix(input logic [23:0] p);
    exp_t e;
    e.pix = p;
    e.pv  = 2'(1 << m_str);
    e.fd  = 1'b0;
    m_cnt++;
    if (m_cnt == 3) begin
      m_cnt = 0;
      m_str++;
      if (m_str == 2) begin
        m_str = 0;
        e.fd  = 1'b1;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || wq.size() != 0) && k < 600) begin
      @(negedge clk);
      k++;
    end
    repeat (14) @(negedge clk);
    chk("drain_pending_pixels", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_rd(input int base);
    int k;
    k = 0;
    while (rd_count == base && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("rd_issued", 32'(rd_count), 32'(base + 1));
  endtask

  // FIFO read-side model: pops on fifo_rd and answers after a latency
  initial begin
    int lat;
    logic [15:0] w;
    fifo_data_valid = 1'b0;
    fifo_data       = 16'h0;
    fifo_count      = 13'd0;
    forever begin
      @(negedge clk);
      fifo_data_valid = 1'b0;
      if (stray_req) begin
        fifo_data_valid = 1'b1;
        fifo_data       = 16'hDEAD;
        stray_req       = 1'b0;
      end else if (fifo_rd && reset_n) begin
        rd_count++;
        rd_times.push_back(cyc);
        w = (wq.size() != 0) ? wq.pop_front() : 16'h0;
        fifo_count = 13'(wq.size());
        if (!drop) begin
          lat = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 4));
          for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            fifo_count = 13'(wq.size());
          end
          fifo_data_valid = 1'b1;
          fifo_data       = w;
        end
      end
      fifo_count = 13'(wq.size());
    end
  end

  // Output monitor: scoreboard pop on every pixel strobe plus protocol checks
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (reset_n) begin
      if (fifo_rd) chk("rd_back_to_back", 32'(prev_rd), 32'd0);
      prev_rd = fifo_rd;
      if (read_error) begin
        err_count++;
        t_err = cyc;
        if (!expect_err) chk("unexpected_read_error", 32'(read_error), 32'd0);
      end
      if (pixel_valid != 2'b00) begin
        pv_count++;
        pv_times.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_pixel", 32'(pixel_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("pixel_data", 32'(pixel_data), 32'(e.pix));
          chk("pixel_valid", 32'(pixel_valid), 32'(e.pv));
          chk("frame_done", 32'(frame_done), 32'(e.fd));
        end
      end else if (frame_done) begin
        chk("frame_done_without_pixel", 32'(frame_done), 32'd0);
      end
    end else begin
      prev_rd = 1'b0;
    end
  end

  initial begin
    int rc, pc, ec;

    tbl[0] = '{1'b0, 1, 16'hF800, 16'h0,    16'h0,    1, 24'hFF0000, 24'h0};
    tbl[1] = '{1'b0, 1, 16'h07E0, 16'h0,    16'h0,    1, 24'h00FF00, 24'h0};
    tbl[2] = '{1'b0, 1, 16'h001F, 16'h0,    16'h0,    1, 24'h0000FF, 24'h0};
    tbl[3] = '{1'b0, 1, 16'hFFFF, 16'h0,    16'h0,    1, 24'hFFFFFF, 24'h0};
    tbl[4] = '{1'b0, 1, 16'h8410, 16'h0,    16'h0,    1, 24'h848284, 24'h0};
    tbl[5] = '{1'b0, 1, 16'h1234, 16'h0,    16'h0,    1, 24'h1045A5, 24'h0};
    tbl[6] = '{1'b1, 3, 16'h1122, 16'h3344, 16'h5566, 2, 24'h112233, 24'h445566};
    tbl[7] = '{1'b1, 3, 16'hABCD, 16'hEF01, 16'h2345, 2, 24'hABCDEF, 24'h012345};
    tbl[8] = '{1'b1, 3, 16'hFFFF, 16'h0000, 16'hFFFF, 2, 24'hFFFF00, 24'h00FFFF};

    reset_n      = 1'b0;
    enable       = 1'b0;
    pack_mode    = 1'b0;
    resync       = 1'b0;
    string_ready = 2'b11;
    repeat (3) @(negedge clk);
    chk("reset_fifo_rd", 32'(fifo_rd), 32'd0);
    chk("reset_pixel_valid", 32'(pixel_valid), 32'd0);
    chk("reset_pixel_data", 32'(pixel_data), 32'd0);
    chk("reset_active_string", 32'(active_string), 32'd0);
    chk("reset_frame_done", 32'(frame_done), 32'd0);
    chk("reset_read_error", 32'(read_error), 32'd0);
    reset_n = 1'b1;
    enable  = 1'b1;
    repeat (2) @(negedge clk);

    // Latency with L=1: pixel at T+3, back-to-back words popped 4 cycles apart
    fixed_lat = 1;
    rd_times.delete();
    pv_times.delete();
    wq.push_back(16'hF800);
    push_pix(24'hFF0000);
    wait_drain();
    chk("lat1_pixel_delay", 32'(pv_times[0] - rd_times[0]), 32'd3);
    rd_times.delete();
    wq.push_back(16'hF800);
    wq.push_back(16'hF800);
    push_pix(24'hFF0000);
    push_pix(24'hFF0000);
    wait_drain();
    chk("min_read_spacing", 32'(rd_times[1] - rd_times[0]), 32'd4);

    // Longest allowed latency still yields a pixel, no error
    fixed_lat = 8;
    rd_times.delete();
    pv_times.delete();
    wq.push_back(16'h07E0);
    push_pix(24'h00FF00);
    wait_drain();
    chk("lat8_pixel_delay", 32'(pv_times[0] - rd_times[0]), 32'd10);

    // Stall in EMIT with string_ready low: nothing moves for 20 cycles
    fixed_lat = 2;
    rc = rd_count;
    wq.push_back(16'h001F);
    wq.push_back(16'h07E0);
    push_pix(24'h0000FF);
    push_pix(24'h00FF00);
    wait_rd(rc);
    string_ready = 2'b00;
    rc = rd_count;
    pc = pv_count;
    repeat (20) @(negedge clk);
    chk("stall_no_pixel", 32'(pv_count), 32'(pc));
    chk("stall_no_read", 32'(rd_count), 32'(rc));
    string_ready = 2'b11;
    wait_drain();
    chk("stall_release_pixels", 32'(pv_count), 32'(pc + 2));
    fixed_lat = 0;

    // Table of decode vectors; pack_mode flips mid-frame on record 7 and must be ignored
    for (int i = 0; i < 9; i++) begin
      if (i < 6)       pack_mode = 1'b0;
      else if (i == 6) pack_mode = 1'b1;
      else             pack_mode = 1'b0;
      rc = rd_count;
      pc = pv_count;
      wq.push_back(tbl[i].w0);
      if (tbl[i].nw > 1) wq.push_back(tbl[i].w1);
      if (tbl[i].nw > 2) wq.push_back(tbl[i].w2);
      push_pix(tbl[i].p0);
      if (tbl[i].np > 1) push_pix(tbl[i].p1);
      wait_drain();
      chk($sformatf("vec%0d_reads", i), 32'(rd_count - rc), 32'(tbl[i].nw));
      chk($sformatf("vec%0d_pixels", i), 32'(pv_count - pc), 32'(tbl[i].np));
      chk($sformatf("vec%0d_active_string", i), 32'(active_string), 32'(m_str));
    end

    // Read timeout in mode 1 phase 1: error at T+8, phase kept, stray valid ignored
    pack_mode = 1'b1;
    repeat (2) @(negedge clk);
    wq.push_back(16'h1122);
    wait_drain();
    drop       = 1'b1;
    expect_err = 1'b1;
    ec = err_count;
    rd_times.delete();
    wq.push_back(16'hBEEF);
    wait_drain();
    chk("timeout_error_count", 32'(err_count - ec), 32'd1);
    chk("timeout_error_time", 32'(t_err - rd_times[0]), 32'd8);
    expect_err = 1'b0;
    drop       = 1'b0;
    pc = pv_count;
    stray_req = 1'b1;
    repeat (10) @(negedge clk);
    chk("stray_valid_ignored", 32'(pv_count), 32'(pc));
    wq.push_back(16'h3344);
    wq.push_back(16'h5566);
    push_pix(24'h112233);
    push_pix(24'h445566);
    wait_drain();

    // Resync with a partial hold pending: next pixel on string 0, decode from phase 0
    wq.push_back(16'h0102);
    wq.push_back(16'h0304);
    wq.push_back(16'h0506);
    push_pix(24'h010203);
    push_pix(24'h040506);
    wait_drain();
    chk("pre_resync_string", 32'(active_string), 32'd1);
    wq.push_back(16'h0A0B);
    wait_drain();
    resync = 1'b1;
    @(negedge clk);
    resync = 1'b0;
    m_cnt = 0;
    m_str = 0;
    wq.push_back(16'hA1A2);
    wq.push_back(16'hB1B2);
    wq.push_back(16'hC1C2);
    push_pix(24'hA1A2B1);
    push_pix(24'hB2C1C2);
    wait_drain();
    chk("post_resync_string", 32'(active_string), 32'd0);

    // Asynchronous reset while a read is outstanding
    drop = 1'b1;
    rc = rd_count;
    wq.push_back(16'h7777);
    wait_rd(rc);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("async_fifo_rd", 32'(fifo_rd), 32'd0);
    chk("async_pixel_valid", 32'(pixel_valid), 32'd0);
    chk("async_pixel_data", 32'(pixel_data), 32'd0);
    chk("async_frame_done", 32'(frame_done), 32'd0);
    chk("async_read_error", 32'(read_error), 32'd0);
    chk("async_active_string", 32'(active_string), 32'd0);
    wq.delete();
    exp_q.delete();
    m_cnt = 0;
    m_str = 0;
    drop = 1'b0;
    pack_mode = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rc = rd_count;
    repeat (10) @(negedge clk);
    chk("idle_empty_fifo_no_read", 32'(rd_count), 32'(rc));
    enable = 1'b0;
    wq.push_back(16'hF800);
    push_pix(24'hFF0000);
    repeat (10) @(negedge clk);
    chk("disabled_no_read", 32'(rd_count), 32'(rc));
    enable = 1'b1;
    wait_drain();
    chk("enabled_read", 32'(rd_count), 32'(rc + 1));

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
